// File: rtl/speech_window_loader_pkg.sv
// Shared constants and state encoding for the LPC analysis-window loader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package speech_window_loader_pkg;

    localparam int ADDR_W  = 11;
    localparam int WINDOW  = 240;
    localparam int FRAME   = 80;
    localparam int L_SHIFT = WINDOW - FRAME;

    // Base of the autocorrelation input buffer in scratch memory.
    localparam logic [ADDR_W-1:0] X_BASE = 11'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SH_RD = 3'd1,
        SH_WR = 3'd2,
        LOAD  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Widen a signed 16-bit speech sample to a 32-bit memory word.
    function automatic logic [31:0] sext16(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

endpackage

// File: rtl/speech_window_loader_addr_gen.sv
// Shared word counter for the shift and load phases; emits read, write and load addresses.
// Latency: addresses are combinational from the counter; counter updates on the next edge.
// Backpressure: counter only moves when inc is asserted, so a stalled load simply holds it.
module window_addr_gen
    import speech_window_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              tc_shift,
    output logic              tc_load
);

    logic [ADDR_W-1:0] cnt;

    // Word counter: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 11'd1;
        end
    end

    // Shift source sits FRAME words above the destination; new samples land after the kept history.
    assign rd_addr  = X_BASE + 11'(FRAME) + cnt;
    assign wr_addr  = X_BASE + cnt;
    assign ld_addr  = X_BASE + 11'(L_SHIFT) + cnt;
    assign tc_shift = (cnt == 11'(L_SHIFT - 1));
    assign tc_load  = (cnt == 11'(FRAME - 1));

endmodule

// File: rtl/speech_window_loader.sv
// Builds one 240-word LPC window: slides history down by 80 words, then appends 80 new samples.
// Latency: start to done is 401 cycles minimum (241 on a zeroing first frame with HIST_CLEAR_EN).
// Backpressure: sampleReady is high throughout LOAD; with sampleValid low the loader waits indefinitely.
// Optional build macro HIST_CLEAR_EN: the first frame after reset zeroes the history instead of copying it.
module speech_window_loader
    import speech_window_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] sampleIn,
    input  logic        sampleValid,
    output logic        sampleReady,
    output logic [10:0] memReadAddr,
    input  logic [31:0] memIn,
    output logic [10:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWriteEn,
    output logic        busy,
    output logic        done
);

    state_t            state;
    logic              hs;
    logic              clr_phase;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] ld_addr;
    logic              tc_shift;
    logic              tc_load;

`ifdef HIST_CLEAR_EN
    logic first_frame;
    // Zeroing pass replaces the copy: one write per cycle, no read, while in SH_RD.
    assign clr_phase = (state == SH_RD) && first_frame;
`else
    assign clr_phase = 1'b0;
`endif

    assign sampleReady = (state == LOAD);
    assign hs          = (state == LOAD) && sampleValid;

    // The same counter serves as i during the shift and k during the load.
    assign cnt_clr = (state == IDLE)
                   || ((state == SH_WR) && tc_shift)
                   || (clr_phase && tc_shift);
    assign cnt_inc = ((state == SH_WR) && !tc_shift)
                   || (clr_phase && !tc_shift)
                   || (hs && !tc_load);

    window_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .ld_addr  (ld_addr),
        .tc_shift (tc_shift),
        .tc_load  (tc_load)
    );

    // Memory port drive: address, data and strobe all decided in the cycle they are used.
    always_comb begin
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        case (state)
            SH_RD: begin
                if (clr_phase) begin
                    memWriteAddr = wr_addr;
                    memWriteEn   = 1'b1;
                end else begin
                    memReadAddr  = rd_addr;
                end
            end
            SH_WR: begin
                // Read data for the address issued in SH_RD arrives now.
                memWriteAddr = wr_addr;
                memOut       = memIn;
                memWriteEn   = 1'b1;
            end
            LOAD: begin
                if (hs) begin
                    memWriteAddr = ld_addr;
                    memOut       = sext16(sampleIn);
                    memWriteEn   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencing with registered busy/done; start outside IDLE is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef HIST_CLEAR_EN
            first_frame <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SH_RD;
                        busy  <= 1'b1;
                    end
                end
                SH_RD: begin
                    if (clr_phase) begin
                        if (tc_shift) begin
                            state <= LOAD;
`ifdef HIST_CLEAR_EN
                            first_frame <= 1'b0;
`endif
                        end
                    end else begin
                        state <= SH_WR;
                    end
                end
                SH_WR: begin
                    if (tc_shift) begin
                        state <= LOAD;
`ifdef HIST_CLEAR_EN
                        first_frame <= 1'b0;
`endif
                    end else begin
                        state <= SH_RD;
                    end
                end
                LOAD: begin
                    if (hs && tc_load) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speech_window_loader.sv
module tb_speech_window_loader;

`ifdef HIST_CLEAR_EN
    localparam int LAT_FIRST = 241;
    localparam bit CLR_FIRST = 1'b1;
`else
    localparam int LAT_FIRST = 401;
    localparam bit CLR_FIRST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic        sampleReady;
    logic [10:0] memReadAddr;
    logic [31:0] memIn;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic        busy;
    logic        done;

    logic [31:0] mem  [0:2047];
    logic [31:0] snap [0:239];
    logic [15:0] samp [0:79];
    logic        do_preload = 1'b0;

    int wr_cnt   = 0;
    int ld_wr    = 0;
    int bad_wr   = 0;
    int done_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_drop = 0;

    always #5 clk = ~clk;

    speech_window_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sampleIn     (sampleIn),
        .sampleValid  (sampleValid),
        .sampleReady  (sampleReady),
        .memReadAddr  (memReadAddr),
        .memIn        (memIn),
        .memWriteAddr (memWriteAddr),
        .memOut       (memOut),
        .memWriteEn   (memWriteEn),
        .busy         (busy),
        .done         (done)
    );

    // Scratch memory model with one-cycle read latency, plus write/done monitors.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int n = 0; n < 240; n++) mem[n] <= 32'(n);
        end else if (memWriteEn) begin
            mem[memWriteAddr] <= memOut;
        end
        if (memWriteEn) begin
            wr_cnt = wr_cnt + 1;
            if (sampleReady) ld_wr = ld_wr + 1;
            if (sampleReady && !sampleValid) bad_wr = bad_wr + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        memIn <= mem[memReadAddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic take_snapshot();
        for (int n = 0; n < 240; n++) snap[n] = mem[n];
    endtask

    // Count window words differing from the expectation derived from the pre-frame snapshot.
    function automatic int window_errs(input bit clr);
        int e = 0;
        for (int n = 0; n < 160; n++)
            if (mem[n] !== (clr ? 32'd0 : snap[n + 80])) e++;
        for (int k = 0; k < 80; k++)
            if (mem[160 + k] !== {{16{samp[k][15]}}, samp[k]}) e++;
        return e;
    endfunction

    // Pulse start, then stream samples until done (lat = cycles after start) or abort point.
    task automatic run_frame(input int mode, input int inj_a, input int inj_b,
                             input int abort_k, output int lat);
        int   k;
        int   cyc;
        logic hs;
        k   = 0;
        lat = -1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            if (done) begin
                lat = cyc;
                break;
            end
            if (busy !== 1'b1) busy_drop++;
            if (abort_k >= 0 && sampleReady && k == abort_k) begin
                lat = cyc;
                break;
            end
            start       = (cyc == inj_a) || (cyc == inj_b);
            sampleValid = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            sampleIn    = samp[k % 80];
            hs          = sampleReady && sampleValid;
            tick(1);
            start = 1'b0;
            if (hs) k++;
            cyc++;
        end
        sampleValid = 1'b0;
    endtask

    initial begin
        int lat;
        int w0, l0, d0, b0;

        reset = 1'b1;
        start = 1'b0;
        sampleIn = '0;
        sampleValid = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_outputs",
              {sampleReady, memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done}, 64'd0);

        // Frame 1: preload word n = n, samples 0x1000+k, valid always high.
        do_preload = 1'b1;
        tick(1);
        do_preload = 1'b0;
        tick(1);
        for (int k = 0; k < 80; k++) samp[k] = 16'h1000 + 16'(k);
        take_snapshot();
        w0 = wr_cnt; l0 = ld_wr; d0 = done_cnt; busy_drop = 0;
        run_frame(0, 0, 0, -1, lat);
        check("f1_latency", 64'(lat), 64'(LAT_FIRST));
        tick(3);
        check("f1_window", 64'(window_errs(CLR_FIRST)), 64'd0);
        check("f1_writes", 64'(wr_cnt - w0), 64'd240);
        check("f1_load_writes", 64'(ld_wr - l0), 64'd80);
        check("f1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("f1_busy_held", 64'(busy_drop), 64'd0);
        check("f1_mem0", 64'(mem[0]), CLR_FIRST ? 64'd0 : 64'd80);
        check("f1_mem159", 64'(mem[159]), CLR_FIRST ? 64'd0 : 64'd239);
        check("f1_mem239", 64'(mem[239]), 64'h0000104F);
        check("f1_idle_after", {62'd0, busy, sampleReady}, 64'd0);

        // Frame 2: sign extension of negative samples; always a copy frame.
        samp[0] = 16'h8000;
        samp[1] = 16'hFFFF;
        samp[2] = 16'h7FFF;
        take_snapshot();
        run_frame(0, 0, 0, -1, lat);
        check("sx_latency", 64'(lat), 64'd401);
        tick(2);
        check("sx_8000", 64'(mem[160]), 64'h00000000FFFF8000);
        check("sx_ffff", 64'(mem[161]), 64'h00000000FFFFFFFF);
        check("sx_7fff", 64'(mem[162]), 64'h0000000000007FFF);
        check("sx_window", 64'(window_errs(1'b0)), 64'd0);

        // Frame 3: sampleValid toggles, low in the first LOAD cycle.
        for (int k = 0; k < 80; k++) samp[k] = 16'h2000 + 16'(3 * k);
        take_snapshot();
        w0 = wr_cnt; l0 = ld_wr; b0 = bad_wr;
        run_frame(1, 0, 0, -1, lat);
        check("bp_latency", 64'(lat), 64'd481);
        tick(2);
        check("bp_load_writes", 64'(ld_wr - l0), 64'd80);
        check("bp_writes", 64'(wr_cnt - w0), 64'd240);
        check("bp_no_write_when_invalid", 64'(bad_wr - b0), 64'd0);
        check("bp_window", 64'(window_errs(1'b0)), 64'd0);

        // Frame 4: start pulses during SH_WR at i=50 (cycle 102) and during LOAD (cycle 330).
        for (int k = 0; k < 80; k++) samp[k] = 16'hC000 ^ 16'(k);
        take_snapshot();
        d0 = done_cnt; busy_drop = 0;
        run_frame(0, 102, 330, -1, lat);
        check("ign_latency", 64'(lat), 64'd401);
        tick(4);
        check("ign_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("ign_busy_held", 64'(busy_drop), 64'd0);
        check("ign_no_restart", {63'd0, busy}, 64'd0);
        check("ign_window", 64'(window_errs(1'b0)), 64'd0);

        // Frame 5: reset in LOAD with k=40, then a complete frame from IDLE.
        run_frame(0, 0, 0, 40, lat);
        check("rst_reached_load", {63'd0, sampleReady}, 64'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_outputs_zero",
              {sampleReady, memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done}, 64'd0);
        tick(2);
        for (int k = 0; k < 80; k++) samp[k] = 16'h0400 + 16'(k);
        take_snapshot();
        run_frame(0, 0, 0, -1, lat);
        check("rst_new_latency", 64'(lat), 64'(LAT_FIRST));
        tick(2);
        check("rst_new_window", 64'(window_errs(CLR_FIRST)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
